// File: rtl/sop_pipe_pkg.sv
// Shared constants and latency helpers for the registered SOP pipeline.
// Pure elaboration-time content: no logic, no latency, no flow control.
package sop_pipe_pkg;

  localparam int MAX_LAT = 15;

  function automatic int lmax(input int n, input int a);
    return (n > a) ? n : a;
  endfunction

  function automatic int total_lat(input int n, input int a, input int o);
    return lmax(n, a) + o;
  endfunction

endpackage

// File: rtl/sop_pipe_delay_line.sv
// D-stage W-bit shift register; latency D cycles, async active-high reset to 0.
// Shifts every cycle unconditionally: no stall, no backpressure.
module delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_stage [D];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < D; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < D; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[D-1];

endmodule

// File: rtl/sop_pipe.sv
// Per-bit x = ~a | (b & c) with per-gate cycle latencies; latency L = max(LAT_NOT,LAT_AND)+LAT_OR.
// Free-running pipe, no backpressure: in_valid is only a tag; toggle_cnt counts cycles where x changed.
module sop_pipe
  import sop_pipe_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LAT_NOT = 1,
  parameter int LAT_AND = 3,
  parameter int LAT_OR  = 1,
  parameter int ALIGN   = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int LMAX    = lmax(LAT_NOT, LAT_AND);
  localparam int L       = total_lat(LAT_NOT, LAT_AND, LAT_OR);
  localparam int PAD_NOT = (ALIGN != 0) ? LMAX - LAT_NOT : 0;
  localparam int PAD_AND = (ALIGN != 0) ? LMAX - LAT_AND : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (LAT_NOT < 1 || LAT_NOT > MAX_LAT || LAT_AND < 1 || LAT_AND > MAX_LAT ||
      LAT_OR < 1 || LAT_OR > MAX_LAT) begin : g_bad_lat
    $error("sop_pipe: every latency must lie in 1..%0d", MAX_LAT);
  end

  logic [WIDTH-1:0] w_not, w_and, w_t0_raw, w_t1_raw, w_t0, w_t1, w_or;
  logic             w_toggle;
  logic [WIDTH-1:0] r_prev_x;
  logic [CNT_W-1:0] r_cnt;

  // Inversion precedes the registers so the branch holds 0 (not ~0) out of reset.
  assign w_not = ~a;
  assign w_and = b & c;

  delay_line #(.W(WIDTH), .D(LAT_NOT)) u_not (
    .i_clk(clk), .i_rst(rst), .i_dat(w_not), .o_dat(w_t0_raw)
  );

  delay_line #(.W(WIDTH), .D(LAT_AND)) u_and (
    .i_clk(clk), .i_rst(rst), .i_dat(w_and), .o_dat(w_t1_raw)
  );

  if (PAD_NOT > 0) begin : g_pad_not
    delay_line #(.W(WIDTH), .D(PAD_NOT)) u_pad_not (
      .i_clk(clk), .i_rst(rst), .i_dat(w_t0_raw), .o_dat(w_t0)
    );
  end else begin : g_nopad_not
    assign w_t0 = w_t0_raw;
  end

  if (PAD_AND > 0) begin : g_pad_and
    delay_line #(.W(WIDTH), .D(PAD_AND)) u_pad_and (
      .i_clk(clk), .i_rst(rst), .i_dat(w_t1_raw), .o_dat(w_t1)
    );
  end else begin : g_nopad_and
    assign w_t1 = w_t1_raw;
  end

  assign w_or = w_t0 | w_t1;

  delay_line #(.W(WIDTH), .D(LAT_OR)) u_or (
    .i_clk(clk), .i_rst(rst), .i_dat(w_or), .o_dat(x)
  );

  delay_line #(.W(1), .D(L)) u_vld (
    .i_clk(clk), .i_rst(rst), .i_dat(in_valid), .o_dat(out_valid)
  );

  assign w_toggle = (x != r_prev_x);

  // Clear wins over increment; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_x <= '0;
      r_cnt    <= '0;
    end else begin
      r_prev_x <= x;
      if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_toggle && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_sop_pipe.sv
// Bench for sop_pipe: aligned, unaligned and 3-bit-counter instances share one stimulus stream;
// a scoreboard queue per instance is filled by the driver and drained by a negedge monitor.
module tb_sop_pipe;

  localparam int L    = 4;  // max(1,3) + 1 with default latencies
  localparam int SKEW = 2;  // unaligned: inverter sample is 2 cycles newer than AND sample

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, clr_cnt;
  logic [3:0] a, b, c;
  logic [3:0] x_al, x_na, x_c3;
  logic       ov_al, ov_na, ov_c3;
  logic [7:0] tc_al, tc_na;
  logic [2:0] tc_c3;

  sop_pipe u_al (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .clr_cnt(clr_cnt),
    .x(x_al), .out_valid(ov_al), .toggle_cnt(tc_al)
  );

  sop_pipe #(.ALIGN(0)) u_na (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .clr_cnt(clr_cnt),
    .x(x_na), .out_valid(ov_na), .toggle_cnt(tc_na)
  );

  sop_pipe #(.CNT_W(3)) u_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .clr_cnt(clr_cnt),
    .x(x_c3), .out_valid(ov_c3), .toggle_cnt(tc_c3)
  );

  typedef struct packed {
    logic [3:0]  x;
    logic [31:0] cyc;
  } ent_t;

  ent_t        q_al[$], q_na[$], q_c3[$];
  logic [3:0]  h_nt[$], h_ad[$];
  logic        h_v[$];
  logic [31:0] h_cyc[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: aligned output for a sample is ~a|(b&c) of that sample, L cycles later.
  // Unaligned: inverter term comes from the sample SKEW cycles newer than the AND term.
  task automatic step(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                      input logic iv, input logic iclr);
    ent_t e;
    int   k;
    a = ia; b = ib; c = ic; in_valid = iv; clr_cnt = iclr;
    if (iv) begin
      e.x   = ~ia | (ib & ic);
      e.cyc = cyc;
      q_al.push_back(e);
      q_c3.push_back(e);
    end
    h_nt.push_back(~ia);
    h_ad.push_back(ib & ic);
    h_v.push_back(iv);
    h_cyc.push_back(cyc);
    if (h_v.size() > SKEW) begin
      k = h_v.size() - 1 - SKEW;
      if (h_v[k]) begin
        e.x   = h_nt[k+SKEW] | h_ad[k];
        e.cyc = h_cyc[k];
        q_na.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    q_al.delete(); q_na.delete(); q_c3.delete();
    h_nt.delete(); h_ad.delete(); h_v.delete(); h_cyc.delete();
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (!rst && ov_al) begin
      chk("al_expected_pending", 32'(q_al.size() != 0), 1);
      if (q_al.size() != 0) begin
        e = q_al.pop_front();
        chk("al_x", 32'(x_al), 32'(e.x));
        chk("al_latency", cyc - e.cyc, L);
      end
    end
    if (!rst && ov_na) begin
      chk("na_expected_pending", 32'(q_na.size() != 0), 1);
      if (q_na.size() != 0) begin
        e = q_na.pop_front();
        chk("na_x", 32'(x_na), 32'(e.x));
        chk("na_latency", cyc - e.cyc, L);
      end
    end
    if (!rst && ov_c3) begin
      chk("c3_expected_pending", 32'(q_c3.size() != 0), 1);
      if (q_c3.size() != 0) begin
        e = q_c3.pop_front();
        chk("c3_x", 32'(x_c3), 32'(e.x));
        chk("c3_latency", cyc - e.cyc, L);
      end
    end
  end

  logic [3:0] tv_a[4] = '{4'hF, 4'hF, 4'hF, 4'h0};
  logic [3:0] tv_b[4] = '{4'h0, 4'h0, 4'hF, 4'h0};
  logic [3:0] tv_c[4] = '{4'hF, 4'h0, 4'hF, 4'h0};
  logic [3:0] tv_x[4] = '{4'h0, 4'h0, 4'hF, 4'hF};
  logic [7:0] s_al, s_na;
  logic [2:0] s_c3;
  logic [3:0] tog;

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; a = '0; b = '0; c = '0;
    #2;
    chk("rst_x_al", 32'(x_al), 0);
    chk("rst_ov_al", 32'(ov_al), 0);
    chk("rst_cnt_al", 32'(tc_al), 0);
    chk("rst_x_na", 32'(x_na), 0);
    chk("rst_cnt_c3", 32'(tc_c3), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, each held 10 cycles with in_valid on the first cycle only.
    for (int i = 0; i < 4; i++) begin
      step(tv_a[i], tv_b[i], tv_c[i], 1'b1, 1'b0);
      repeat (9) step(tv_a[i], tv_b[i], tv_c[i], 1'b0, 1'b0);
      chk("vec_x", 32'(x_al), 32'(tv_x[i]));
    end

    // Static-hazard step: 0,0,1 -> 1,1,1 keeps the function at 1.
    repeat (10) step(4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    s_al = tc_al; s_na = tc_na; s_c3 = tc_c3;
    repeat (10) step(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    chk("hazard_na_toggles", 32'(tc_na - s_na), 2);
    chk("hazard_al_toggles", 32'(tc_al - s_al), 0);
    chk("hazard_c3_toggles", 32'(tc_c3 - s_c3), 0);
    chk("hazard_na_final", 32'(x_na), 4'hF);

    // Per-channel independence.
    step(4'b1010, 4'b0110, 4'b1100, 1'b1, 1'b0);
    repeat (5) step(4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0);
    chk("chan_x", 32'(x_al), 4'b0101);

    repeat (300) step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    repeat (6) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Toggle a every cycle with b=c=0: every output bit flips every cycle.
    tog = 4'h0;
    repeat (24) begin
      tog = ~tog;
      step(tog, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    chk("sat_c3", 32'(tc_c3), 7);
    repeat (3) begin
      tog = ~tog;
      step(tog, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    chk("sat_hold_c3", 32'(tc_c3), 7);
    tog = ~tog;
    step(tog, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("clr_zero_c3", 32'(tc_c3), 0);
    chk("clr_zero_al", 32'(tc_al), 0);
    tog = ~tog;
    step(tog, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("clr_then_one_c3", 32'(tc_c3), 1);

    // Asynchronous reset between edges while samples are in flight.
    repeat (5) step(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    flush_model();
    #1;
    chk("arst_x_al", 32'(x_al), 0);
    chk("arst_ov_al", 32'(ov_al), 0);
    chk("arst_cnt_al", 32'(tc_al), 0);
    chk("arst_ov_na", 32'(ov_na), 0);
    chk("arst_cnt_na", 32'(tc_na), 0);
    chk("arst_cnt_c3", 32'(tc_c3), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_ov", 32'(ov_al), 0);
    for (int i = 0; i < L; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
      chk("post_rst_ov_window", 32'(ov_al), (i < L - 1) ? 0 : 1);
    end

    repeat (10) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("drain_al", q_al.size(), 0);
    chk("drain_na", q_na.size(), 0);
    chk("drain_c3", q_c3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
